coherence_bus_arbiter: RTL
==========================

# coherence_bus_arbiter

Snoop-bus responder for the two-core MSI data-cache system. It collects read-miss, write-miss and invalidate requests from both cache controllers and arbitrates between them round-robin. For the winning request it snoops the other core's cache, then chooses the fill source: the peer cache or data memory. It drives `grant`, `cpu_datasel`, `BOCI`, `cpu_search`, `invalidate_from_other_cpu` and forwarded data back to the caches.

## Interface
Parameters:
- `ADDR_W`, 13: word-address width on the bus.
- `DATA_W`, 16: forwarded data-word width.

Ports (index 0/1 = core 0/1). One clock; reset is asynchronous and active-high.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `read_miss` input [1:0]: one-cycle read-miss request pulse per core.
- `write_miss` input [1:0]: one-cycle write-miss request pulse per core.
- `invalidate` input [1:0]: one-cycle write-hit-on-SHARED upgrade pulse per core.
- `BICO0`, `BICO1` input ADDR_W: requesting address from each core, valid with its pulse.
- `cpu_search_found` input [1:0]: snooped core holds the `BOCI` line.
- `block_state0`, `block_state1` input 2: `blk_state_t` of the snooped line.
- `send_other_proc_data0`, `send_other_proc_data1` input DATA_W: snooped word.
- `mem_rdy` input 1: data memory ready (`u_rdy`).
- `grant` output [1:0]: bus granted to the requester.
- `cpu_datasel0`, `cpu_datasel1` output 2: fill source, `SOURCE_DMEM`=00 or `SOURCE_OTHER_PROC`=01.
- `other_proc_data0`, `other_proc_data1` output DATA_W: forwarded word to the requester.
- `BOCI` output ADDR_W: broadcast address to the snooped core.
- `cpu_search` output [1:0]: snoop-lookup strobe to the non-requesting core.
- `invalidate_from_other_cpu` output [1:0]: invalidate strobe to the non-requesting core.
- `busy` output 1: arbiter not in IDLE.

## Operation
- **Pending latch.** Each core has a 2-bit pending register of type `bus_req_t` (`REQ_NONE`/`REQ_RD`/`REQ_WR`/`REQ_INV`), plus a captured address.
  - A pulse loads the register unless a request from that core is already pending. A duplicate is ignored.
  - Two or more pulses from one core in the same cycle are encoded with priority WR > RD > INV.
  - The register is cleared on the last cycle of service.
- **Arbitration.** Round-robin. `last` is the index of the core served most recently; reset value 1, so core 0 wins first.
  - If both cores are pending, the core != `last` wins.
  - On winning, the arbiter latches `req_id` and type; `other` = ~`req_id`.
- **FSM states.** IDLE, SNOOP, FWD, MEM, INV.
- **IDLE.** If any request is pending, arbitrate. Go to INV if the type is `REQ_INV`, else to SNOOP.
- **SNOOP (1 cycle).**
  - `BOCI` = captured address; `cpu_search[other]`=1.
  - If `cpu_search_found[other]` and the state is SHARED or MODIFIED, sample the snooped word into a register and go to FWD.
  - Otherwise go to MEM.
  - For `REQ_WR`, the found flag is registered as `peer_hit`.
- **FWD (1 cycle).**
  - `grant[req_id]`=1; `cpu_datasel[req_id]`=01; `other_proc_data[req_id]` = the registered word.
  - For `REQ_WR`: `invalidate_from_other_cpu[other]`=1.
  - Clear pending, set `last`=`req_id`, go to IDLE.
- **MEM.**
  - `grant[req_id]`=1; `cpu_datasel[req_id]`=00. Hold until `mem_rdy`.
  - On the `mem_rdy` cycle:
    - For `REQ_WR` with `peer_hit`: `invalidate_from_other_cpu[other]`=1.
    - Clear pending, update `last`, go to IDLE.
- **INV (1 cycle).**
  - `BOCI` = address; `invalidate_from_other_cpu[other]`=1; `grant[req_id]`=1.
  - Clear pending, update `last`, go to IDLE.
- `BOCI` holds its last value outside SNOOP, INV and the invalidate cycles.
- Non-granted core: `cpu_datasel` is 00 and `other_proc_data` is 0.

## Timing
- **Reset.** All outputs are 0; pending is `REQ_NONE`; `last`=1; state IDLE.
- **Reset mid-operation.** Aborts immediately. No `grant` or invalidate is issued after `rst` rises.
- **Latencies** (pulse in cycle N):
  - Pending is visible at N+1; SNOOP or INV at N+2.
  - FWD grant in N+3.
  - MEM grant from N+3 until `mem_rdy`.
- **Pulse during service.** A pulse arriving while the same core is being serviced is ignored (duplicate rule).
- **Pulse from the other core.** The pulse is latched and waits. The next request enters SNOOP or INV on the cycle after the return to IDLE.
- **Simultaneous pulses from both cores.** Both are latched; round-robin decides the order.

## Configuration
- **`SNOOP_FWD_EN` defined.** Cache-to-cache forwarding as described above.
- **`SNOOP_FWD_EN` undefined.**
  - SNOOP always proceeds to MEM; `cpu_datasel` is always 00; FWD is not compiled.
  - `peer_hit` and write-miss invalidation are retained.

## Structure
- **Package `common`:**
  - `bus_req_t`.
  - Arbiter state enum `arb_state_t`.
  - `SOURCE_DMEM` and `SOURCE_OTHER_PROC` constants, shared with the cache controller and replacing its local parameters.
  - Existing `blk_state_t`.
- **Sub-module `rr_arbiter2`:** two requests plus the `last` pointer in, one-hot winner out; purely combinational.

## Test plan
- Core 0 `read_miss`, addr 0x0A4; core 1 `cpu_search_found`=1, MODIFIED, word 0xBEEF -> cycle N+3: `grant[0]`, `cpu_datasel0`=01, `other_proc_data0`=0xBEEF, no invalidate.
- Core 1 `write_miss`, addr 0x1F0; peer not found; `mem_rdy` asserted 3 cycles later -> `grant[1]` held through the MEM wait, `cpu_datasel1`=00, `invalidate_from_other_cpu`=00.
- Core 0 `invalidate`, addr 0x033 -> cycle N+2: `BOCI`=0x033, `invalidate_from_other_cpu[1]`=1, `grant[0]`=1 for exactly 1 cycle.
- Both cores pulse `read_miss` in the same cycle after reset -> core 0 served first, core 1 served immediately after; a repeat simultaneous pair is served core 0 first again (`last`=1).
- `rst` asserted during MEM -> `grant`=0 in the same cycle; pending cleared; no invalidate issued.
- `SNOOP_FWD_EN` undefined, peer MODIFIED on a write miss -> `cpu_datasel`=00 from memory, `invalidate_from_other_cpu[other]`=1 on the `mem_rdy` cycle.

Source files
------------

// File: rtl/coherence_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// common: types and constants shared by the snoop-bus arbiter and the MSI
// cache controllers.
//   bus_req_t    - pending bus request kind per core
//   arb_state_t  - arbiter FSM state
//   blk_state_t  - MSI state of a cache line
//   SOURCE_*     - cache fill source select (cpu_datasel encoding)
// No ports (package).
// -----------------------------------------------------------------------------
package common;

  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_RD   = 2'b01,
    REQ_WR   = 2'b10,
    REQ_INV  = 2'b11
  } bus_req_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNOOP = 3'd1,
    FWD   = 3'd2,
    MEM   = 3'd3,
    INV   = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    BLK_INVALID  = 2'b00,
    BLK_SHARED   = 2'b01,
    BLK_MODIFIED = 2'b10
  } blk_state_t;

  localparam logic [1:0] SOURCE_DMEM       = 2'b00;
  localparam logic [1:0] SOURCE_OTHER_PROC = 2'b01;

  // Several pulses from one core in one cycle collapse to a single request;
  // a write miss dominates because it subsumes the read.
  function automatic bus_req_t encode_req(input logic rd, input logic wr, input logic inv);
    if (wr)  return REQ_WR;
    if (rd)  return REQ_RD;
    if (inv) return REQ_INV;
    return REQ_NONE;
  endfunction

  function automatic logic [1:0] onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/coherence_bus_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2: two-requester round-robin pick, purely combinational.
//   req  [1:0] in  - pending request per core
//   last       in  - index of the core served most recently
//   win  [1:0] out - one-hot winner (00 when nothing is requested)
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    // On contention the core that was not served last goes first.
    if (req == 2'b11) win = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// -----------------------------------------------------------------------------
// coherence_bus_arbiter: snoop-bus responder for a two-core MSI cache system.
// Latches read-miss / write-miss / invalidate pulses per core, arbitrates
// round-robin, snoops the peer cache and selects the fill source.
//
// Build option: define SNOOP_FWD_EN to enable cache-to-cache forwarding
// (FWD state). Without it every miss is filled from data memory.
//
// Ports (index 0/1 = core 0/1):
//   clk, rst                    clock, asynchronous active-high reset
//   read_miss/write_miss/invalidate [1:0]  request pulses
//   BICO0, BICO1                request addresses
//   cpu_search_found [1:0]      snoop hit from each core
//   block_state0/1              MSI state of the snooped line
//   send_other_proc_data0/1     snooped data word
//   mem_rdy                     data memory ready
//   grant [1:0]                 bus granted to requester
//   cpu_datasel0/1              fill source select
//   other_proc_data0/1          forwarded word to requester
//   BOCI                        broadcast address to snooped core
//   cpu_search [1:0]            snoop strobe
//   invalidate_from_other_cpu [1:0]  invalidate strobe
//   busy                        arbiter not idle
// -----------------------------------------------------------------------------
module coherence_bus_arbiter
  import common::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        read_miss,
  input  logic [1:0]        write_miss,
  input  logic [1:0]        invalidate,
  input  logic [ADDR_W-1:0] BICO0,
  input  logic [ADDR_W-1:0] BICO1,
  input  logic [1:0]        cpu_search_found,
  input  logic [1:0]        block_state0,
  input  logic [1:0]        block_state1,
  input  logic [DATA_W-1:0] send_other_proc_data0,
  input  logic [DATA_W-1:0] send_other_proc_data1,
  input  logic              mem_rdy,
  output logic [1:0]        grant,
  output logic [1:0]        cpu_datasel0,
  output logic [1:0]        cpu_datasel1,
  output logic [DATA_W-1:0] other_proc_data0,
  output logic [DATA_W-1:0] other_proc_data1,
  output logic [ADDR_W-1:0] BOCI,
  output logic [1:0]        cpu_search,
  output logic [1:0]        invalidate_from_other_cpu,
  output logic              busy
);

  arb_state_t        state_reg;
  logic              req_id_reg;
  bus_req_t          type_reg;
  logic              last_reg;
  logic              peer_hit_reg;
  logic [1:0]        grant_reg, search_reg, inv_reg;
  logic [1:0]        datasel0_reg, datasel1_reg;
  logic [DATA_W-1:0] data0_reg, data1_reg;
  logic [ADDR_W-1:0] boci_reg;

  logic [1:0][1:0]        pend_vec;
  logic [1:0][ADDR_W-1:0] addr_vec;
  logic [1:0]             pend_any, win, clr;
  logic                   other, done, win_id, peer_found;

  assign other      = ~req_id_reg;
  assign win_id     = win[1];
  assign peer_found = cpu_search_found[other];
  // Last cycle of any service; the served core's pending slot frees here.
  assign done = (state_reg == FWD) || (state_reg == INV) ||
                ((state_reg == MEM) && mem_rdy);

  // Per-core pending latch. While a request is pending (including its last
  // service cycle) further pulses from that core are dropped.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pend
    bus_req_t          pend_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              pulse;

    assign pulse        = read_miss[gi] | write_miss[gi] | invalidate[gi];
    assign clr[gi]      = done && (req_id_reg == 1'(gi));
    assign pend_any[gi] = (pend_reg != REQ_NONE);
    assign pend_vec[gi] = pend_reg;
    assign addr_vec[gi] = addr_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_reg <= REQ_NONE;
        addr_reg <= '0;
      end else if (clr[gi]) begin
        pend_reg <= REQ_NONE;
      end else if (!pend_any[gi] && pulse) begin
        pend_reg <= encode_req(read_miss[gi], write_miss[gi], invalidate[gi]);
        addr_reg <= (gi == 0) ? BICO0 : BICO1;
      end
    end
  end

  rr_arbiter2 u_rr (
    .req  (pend_any),
    .last (last_reg),
    .win  (win)
  );

`ifdef SNOOP_FWD_EN
  logic [1:0]        peer_state;
  logic [DATA_W-1:0] peer_word;
  logic              peer_valid;
  assign peer_state = other ? block_state1 : block_state0;
  assign peer_word  = other ? send_other_proc_data1 : send_other_proc_data0;
  assign peer_valid = peer_found && ((peer_state == BLK_SHARED) || (peer_state == BLK_MODIFIED));
`else
  logic unused_ok;
  assign unused_ok = ^{block_state0, block_state1, send_other_proc_data0, send_other_proc_data1};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      req_id_reg   <= 1'b0;
      type_reg     <= REQ_NONE;
      last_reg     <= 1'b1;
      peer_hit_reg <= 1'b0;
      grant_reg    <= 2'b00;
      search_reg   <= 2'b00;
      inv_reg      <= 2'b00;
      datasel0_reg <= SOURCE_DMEM;
      datasel1_reg <= SOURCE_DMEM;
      data0_reg    <= '0;
      data1_reg    <= '0;
      boci_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|pend_any) begin
            req_id_reg   <= win_id;
            type_reg     <= bus_req_t'(pend_vec[win_id]);
            boci_reg     <= addr_vec[win_id];
            peer_hit_reg <= 1'b0;
            if (bus_req_t'(pend_vec[win_id]) == REQ_INV) begin
              state_reg <= INV;
              grant_reg <= onehot(win_id);
              inv_reg   <= onehot(~win_id);
            end else begin
              state_reg  <= SNOOP;
              search_reg <= onehot(~win_id);
            end
          end
        end
        SNOOP: begin
          search_reg   <= 2'b00;
          grant_reg    <= onehot(req_id_reg);
          peer_hit_reg <= (type_reg == REQ_WR) && peer_found;
`ifdef SNOOP_FWD_EN
          if (peer_valid) begin
            state_reg <= FWD;
            if (req_id_reg) begin
              datasel1_reg <= SOURCE_OTHER_PROC;
              data1_reg    <= peer_word;
            end else begin
              datasel0_reg <= SOURCE_OTHER_PROC;
              data0_reg    <= peer_word;
            end
            // A write miss served from the peer still kills the peer's copy.
            if (type_reg == REQ_WR) inv_reg <= onehot(other);
          end else begin
            state_reg <= MEM;
          end
`else
          state_reg <= MEM;
`endif
        end
`ifdef SNOOP_FWD_EN
        FWD: begin
          grant_reg    <= 2'b00;
          inv_reg      <= 2'b00;
          datasel0_reg <= SOURCE_DMEM;
          datasel1_reg <= SOURCE_DMEM;
          data0_reg    <= '0;
          data1_reg    <= '0;
          last_reg     <= req_id_reg;
          state_reg    <= IDLE;
        end
`endif
        MEM: begin
          if (mem_rdy) begin
            grant_reg <= 2'b00;
            last_reg  <= req_id_reg;
            state_reg <= IDLE;
          end
        end
        INV: begin
          grant_reg <= 2'b00;
          inv_reg   <= 2'b00;
          last_reg  <= req_id_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grant            = grant_reg;
  assign cpu_search       = search_reg;
  assign cpu_datasel0     = datasel0_reg;
  assign cpu_datasel1     = datasel1_reg;
  assign other_proc_data0 = data0_reg;
  assign other_proc_data1 = data1_reg;
  assign BOCI             = boci_reg;
  assign busy             = (state_reg != IDLE);
  // The write-miss invalidate from memory must coincide with the mem_rdy
  // cycle itself, so that term cannot wait for a register.
  assign invalidate_from_other_cpu = inv_reg |
      (((state_reg == MEM) && mem_rdy && (type_reg == REQ_WR) && peer_hit_reg) ?
       onehot(other) : 2'b00);

endmodule
